// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline registers.
//   - controller state encodings
//   - NOP instruction loaded into a flushed F/D register (addi x0,x0,0)
//   - register index width
package pipeline_control_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_DRAIN   = 2'd0,
        ST_RUN     = 2'd1,
        ST_MC_WAIT = 2'd2
    } ctrl_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_control.
//   master : the controller (consumes hazard info, drives stall/flush/abort)
//   slave  : the datapath (drives hazard info, consumes stall/flush/abort)
interface pipeline_control_if;
    import pipeline_control_pkg::*;

    // Hazard information from decode/execute and the memories
    logic [REG_IDX_W-1:0] d_rs1, d_rs2, e_rd;
    logic                 d_uses_rs1, d_uses_rs2;
    logic                 e_is_load, e_redirect, e_mc_start;
    logic                 mc_done, imem_ready;

    // Pipeline controls
    logic pc_stall, fd_stall, de_stall;
    logic fd_flush, de_flush, em_flush;
    logic mc_abort;

    modport master (
        input  d_rs1, d_rs2, d_uses_rs1, d_uses_rs2, e_rd, e_is_load,
        input  e_redirect, e_mc_start, mc_done, imem_ready,
        output pc_stall, fd_stall, de_stall, fd_flush, de_flush, em_flush, mc_abort
    );

    modport slave (
        output d_rs1, d_rs2, d_uses_rs1, d_uses_rs2, e_rd, e_is_load,
        output e_redirect, e_mc_start, mc_done, imem_ready,
        input  pc_stall, fd_stall, de_stall, fd_flush, de_flush, em_flush, mc_abort
    );

endinterface

// File: rtl/pipeline_control_load_use_detect.sv
// Combinational load-use hazard detector.
//   in : d_rs1/d_rs2 + use flags (decode), e_rd + e_is_load (execute)
//   out: hazard -- decode reads a register the load in execute has not yet produced.
// x0 is never a hazard since it is hard-wired to zero.
module load_use_detect
    import pipeline_control_pkg::*;
(
    input  logic [REG_IDX_W-1:0] d_rs1,
    input  logic [REG_IDX_W-1:0] d_rs2,
    input  logic                 d_uses_rs1,
    input  logic                 d_uses_rs2,
    input  logic [REG_IDX_W-1:0] e_rd,
    input  logic                 e_is_load,
    output logic                 hazard
);

    always_comb begin
        hazard = e_is_load && (e_rd != '0) &&
                 ((d_uses_rs1 && (d_rs1 == e_rd)) || (d_uses_rs2 && (d_rs2 == e_rd)));
    end

endmodule

// File: rtl/pipeline_control.sv
// Central hazard / sequencing controller for the five-stage pipeline.
//   clock, reset (async, active-high)
//   bus  : pipeline_control_if.master -- hazard inputs in, stall/flush/abort out
// Priority in RUN: redirect > multi-cycle op > load-use > imem wait.
// After reset the pipe is drained for DRAIN_CYCLES cycles; a multi-cycle op
// is aborted after MC_TIMEOUT cycles in MC_WAIT.
// Outputs are Mealy; only state and cnt are registered.
//
// Optional build macro PIPELINE_CONTROL_PERF_EN adds stall_cycles,
// flush_events and mc_aborts performance counters (not counted in DRAIN).
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int MC_TIMEOUT   = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_control_if.master    bus
`ifdef PIPELINE_CONTROL_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events,
    output logic [31:0]           mc_aborts
`endif
);

    localparam int CNT_W = $clog2(max_int(MC_TIMEOUT, DRAIN_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MC_LAST    = CNT_W'(MC_TIMEOUT - 1);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    load_use_detect u_load_use (
        .d_rs1      (bus.d_rs1),
        .d_rs2      (bus.d_rs2),
        .d_uses_rs1 (bus.d_uses_rs1),
        .d_uses_rs2 (bus.d_uses_rs2),
        .e_rd       (bus.e_rd),
        .e_is_load  (bus.e_is_load),
        .hazard     (load_use)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_DRAIN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus.pc_stall = 1'b0;
        bus.fd_stall = 1'b0;
        bus.de_stall = 1'b0;
        bus.fd_flush = 1'b0;
        bus.de_flush = 1'b0;
        bus.em_flush = 1'b0;
        bus.mc_abort = 1'b0;

        unique case (state_q)
            ST_DRAIN: begin
                // Hold the PC and fill every stage with bubbles
                bus.pc_stall = 1'b1;
                bus.fd_flush = 1'b1;
                bus.de_flush = 1'b1;
                bus.em_flush = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.e_redirect) begin
                    // Squash the two wrong-path instructions; a pending mc op is on the wrong path too
                    bus.fd_flush = 1'b1;
                    bus.de_flush = 1'b1;
                end else if (bus.e_mc_start && !bus.mc_done) begin
                    bus.pc_stall = 1'b1;
                    bus.fd_stall = 1'b1;
                    bus.de_stall = 1'b1;
                    bus.em_flush = 1'b1;
                    state_d      = ST_MC_WAIT;
                    cnt_d        = CNT_W'(1);
                end else if (load_use) begin
                    // One-cycle bubble into E while the load completes
                    bus.pc_stall = 1'b1;
                    bus.fd_stall = 1'b1;
                    bus.de_flush = 1'b1;
                end else if (!bus.imem_ready) begin
                    bus.pc_stall = 1'b1;
                    bus.fd_flush = 1'b1;
                end
            end

            ST_MC_WAIT: begin
                if (bus.mc_done) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q < MC_LAST) begin
                    bus.pc_stall = 1'b1;
                    bus.fd_stall = 1'b1;
                    bus.de_stall = 1'b1;
                    bus.em_flush = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                end else begin
                    // Timed out: drop the op (bubble into E/M) and let the pipe move on
                    bus.mc_abort = 1'b1;
                    bus.em_flush = 1'b1;
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                end
            end

            default: begin
                state_d = ST_DRAIN;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;
    logic [31:0] mc_aborts_q, mc_aborts_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        mc_aborts_d    = mc_aborts_q;
        if (state_q != ST_DRAIN && bus.pc_stall)
            stall_cycles_d = stall_cycles_q + 32'd1;
        if (state_q == ST_RUN && bus.e_redirect)
            flush_events_d = flush_events_q + 32'd1;
        if (bus.mc_abort)
            mc_aborts_d = mc_aborts_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            mc_aborts_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            mc_aborts_q    <= mc_aborts_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
    assign mc_aborts    = mc_aborts_q;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control (MC_TIMEOUT=8, DRAIN_CYCLES=2).
// Outputs are compared as a 7-bit word {pc_stall,fd_stall,de_stall,fd_flush,de_flush,em_flush,mc_abort}.
module tb_pipeline_control;
    import pipeline_control_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pipeline_control_if bus ();

`ifdef PIPELINE_CONTROL_PERF_EN
    logic [31:0] stall_cycles, flush_events, mc_aborts;
`endif

    pipeline_control #(.MC_TIMEOUT(8), .DRAIN_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef PIPELINE_CONTROL_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
        .mc_aborts    (mc_aborts)
`endif
    );

    always #5 clock = ~clock;

    localparam logic [6:0] O_NONE  = 7'b000_000_0;
    localparam logic [6:0] O_DRAIN = 7'b100_111_0;
    localparam logic [6:0] O_LU    = 7'b110_010_0;
    localparam logic [6:0] O_REDIR = 7'b000_110_0;
    localparam logic [6:0] O_MC    = 7'b111_001_0;
    localparam logic [6:0] O_IMEM  = 7'b100_100_0;
    localparam logic [6:0] O_ABORT = 7'b000_001_1;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       ld, redir, mcs, mcd, imr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string nm, input logic [6:0] exp);
        logic [6:0] got;
        got = {bus.pc_stall, bus.fd_stall, bus.de_stall,
               bus.fd_flush, bus.de_flush, bus.em_flush, bus.mc_abort};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", nm, got, exp);
        end
    endtask

    task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic idle();
        bus.d_rs1 = '0; bus.d_rs2 = '0; bus.d_uses_rs1 = 0; bus.d_uses_rs2 = 0;
        bus.e_rd = '0; bus.e_is_load = 0; bus.e_redirect = 0;
        bus.e_mc_start = 0; bus.mc_done = 0; bus.imem_ready = 1;
    endtask

    task automatic apply(input vec_t v);
        bus.d_rs1 = v.rs1; bus.d_rs2 = v.rs2; bus.d_uses_rs1 = v.u1; bus.d_uses_rs2 = v.u2;
        bus.e_rd = v.rd; bus.e_is_load = v.ld; bus.e_redirect = v.redir;
        bus.e_mc_start = v.mcs; bus.mc_done = v.mcd; bus.imem_ready = v.imr;
    endtask

    // Reset for 3 cycles, release at a negedge, check the 2-cycle drain and RUN entry
    task automatic reset_and_drain(input string tag);
        reset = 1'b1;
        idle();
        repeat (3) @(negedge clock);
        #1 check({tag, "_in_reset"}, O_DRAIN);
        reset = 1'b0;
        #1 check({tag, "_drain0"}, O_DRAIN);
        @(negedge clock);
        #1 check({tag, "_drain1"}, O_DRAIN);
        @(negedge clock);
        #1 check({tag, "_run"}, O_NONE);
    endtask

    initial begin
        //          name             rs1 rs2 u1 u2 rd  ld rdr mcs mcd imr exp
        vecs[0]  = '{"idle",         0,  0,  0, 0, 0,  0, 0,  0,  0,  1,  O_NONE};
        vecs[1]  = '{"lu_rs2",       0,  5,  0, 1, 5,  1, 0,  0,  0,  1,  O_LU};
        vecs[2]  = '{"lu_x0",        0,  0,  0, 1, 0,  1, 0,  0,  0,  1,  O_NONE};
        vecs[3]  = '{"lu_rs1",       7,  3,  1, 1, 7,  1, 0,  0,  0,  1,  O_LU};
        vecs[4]  = '{"lu_rs1_unused",7,  3,  0, 1, 7,  1, 0,  0,  0,  1,  O_NONE};
        vecs[5]  = '{"match_noload", 9,  9,  1, 1, 9,  0, 0,  0,  0,  1,  O_NONE};
        vecs[6]  = '{"redir_lu",     0,  5,  0, 1, 5,  1, 1,  0,  0,  1,  O_REDIR};
        vecs[7]  = '{"redir_mc",     0,  0,  0, 0, 0,  0, 1,  1,  0,  1,  O_REDIR};
        vecs[8]  = '{"mc_1cycle",    0,  0,  0, 0, 0,  0, 0,  1,  1,  1,  O_NONE};
        vecs[9]  = '{"imem_wait",    0,  0,  0, 0, 0,  0, 0,  0,  0,  0,  O_IMEM};
        vecs[10] = '{"lu_over_imem", 4,  0,  1, 0, 4,  1, 0,  0,  0,  0,  O_LU};
        vecs[11] = '{"mc1_lu",       4,  0,  1, 0, 4,  1, 0,  1,  1,  1,  O_LU};
        vecs[12] = '{"redir_imem",   0,  0,  0, 0, 0,  0, 1,  0,  0,  0,  O_REDIR};

        reset_and_drain("r1");

        // Single-cycle RUN vectors: none of them leaves RUN
        for (int i = 0; i < 13; i++) begin
            @(negedge clock);
            apply(vecs[i]);
            #1 check(vecs[i].name, vecs[i].exp);
        end
        @(negedge clock);
        idle();
        #1 check("after_vecs", O_NONE);

        // Multi-cycle op done on the 4th cycle: 3 stall cycles
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            bus.e_mc_start = 1'b1;
            bus.mc_done    = (c == 4);
            #1 check($sformatf("mc4_c%0d", c), (c == 4) ? O_NONE : O_MC);
        end
        @(negedge clock);
        idle();
        #1 check("mc4_after", O_NONE);
        @(negedge clock);
        apply(vecs[1]);
        #1 check("mc4_back_in_run", O_LU);

        // Fresh reset so the perf counters start from zero for the timeout case
        reset_and_drain("r2");
`ifdef PIPELINE_CONTROL_PERF_EN
        check32("perf_stall_rst", stall_cycles, 32'd0);
        check32("perf_abort_rst", mc_aborts, 32'd0);
`endif
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            bus.e_mc_start = 1'b1;
            #1 check($sformatf("tmo_c%0d", c), (c == 8) ? O_ABORT : O_MC);
        end
        @(negedge clock);
        idle();
        #1 check("tmo_abort_once", O_NONE);
`ifdef PIPELINE_CONTROL_PERF_EN
        check32("perf_stall_cycles", stall_cycles, 32'd7);
        check32("perf_mc_aborts", mc_aborts, 32'd1);
        check32("perf_flush_events", flush_events, 32'd0);
`endif

        // Instruction memory wait for 3 cycles
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            bus.imem_ready = 1'b0;
            #1 check($sformatf("imem_c%0d", c), O_IMEM);
        end
        @(negedge clock);
        bus.imem_ready = 1'b1;
        bus.e_redirect = 1'b1;
        #1 check("imem_then_redir", O_REDIR);
`ifdef PIPELINE_CONTROL_PERF_EN
        @(negedge clock);
        idle();
        #1 check32("perf_flush_one", flush_events, 32'd1);
`endif

        // Reset during MC_WAIT returns to DRAIN at once without an abort
        @(negedge clock);
        idle();
        bus.e_mc_start = 1'b1;
        #1 check("mcr_enter", O_MC);
        @(negedge clock);
        #1 check("mcr_wait", O_MC);
        #1 reset = 1'b1;
        #1 check("mcr_reset_now", O_DRAIN);
`ifdef PIPELINE_CONTROL_PERF_EN
        check32("perf_mc_aborts_rst", mc_aborts, 32'd0);
`endif
        @(negedge clock);
        #1 check("mcr_reset_hold", O_DRAIN);
        reset = 1'b0;
        idle();
        #1 check("mcr_drain0", O_DRAIN);
        @(negedge clock);
        #1 check("mcr_drain1", O_DRAIN);
        @(negedge clock);
        #1 check("mcr_run", O_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the stall/flush controls of the F/D, D/E and E/M pipeline registers and the PC hold. It resolves, in priority order, control redirects, multi-cycle execute operations, load-use hazards and instruction-memory wait states. It also runs a post-reset drain sequence and a watchdog on multi-cycle operations.

## Interface
- MC_TIMEOUT, 64: maximum cycles in MC_WAIT before the operation is aborted (≥2).
- DRAIN_CYCLES, 2: cycles spent in DRAIN after reset release (≥1).
- clock  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- d_rs1, d_rs2  in  5  source registers of the instruction in decode.
- d_uses_rs1, d_uses_rs2  in  1  decode instruction actually reads rs1/rs2.
- e_rd  in  5  destination register of the instruction in execute.
- e_is_load  in  1  execute instruction is a load.
- e_redirect  in  1  execute resolved a taken branch/jump; the PC is redirected this cycle.
- e_mc_start  in  1  execute holds a multi-cycle op (div/mul) that has not completed.
- mc_done  in  1  multi-cycle unit result valid this cycle.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_stall, fd_stall, de_stall  out  1  hold PC / F/D / D/E register.
- fd_flush, de_flush, em_flush  out  1  load NOP (32'h00000013) or bubble into F/D / D/E / E/M.
- mc_abort  out  1  single-cycle pulse: multi-cycle op timed out.

## Operation
- States: DRAIN, RUN, MC_WAIT. An internal counter cnt is $clog2(max(MC_TIMEOUT,DRAIN_CYCLES))+1 bits wide.
- Reset: state=DRAIN, cnt=0. While reset is high, all outputs take their DRAIN values.
- DRAIN outputs: pc_stall=1; fd_flush=de_flush=em_flush=1; all other outputs 0.
- DRAIN transitions: cnt increments each cycle; when cnt==DRAIN_CYCLES-1, next state is RUN and cnt returns to 0.
- RUN evaluates the following conditions in priority order. The first match drives the outputs; all unlisted outputs are 0.
  1. e_redirect: fd_flush=de_flush=1. Any e_mc_start in the same cycle is ignored.
  2. e_mc_start & !mc_done: pc_stall=fd_stall=de_stall=1, em_flush=1. Next state is MC_WAIT with cnt=1.
  3. Load-use: e_is_load & e_rd!=0 & ((d_uses_rs1 & d_rs1==e_rd) | (d_uses_rs2 & d_rs2==e_rd)). Drives pc_stall=fd_stall=1, de_flush=1.
  4. !imem_ready: pc_stall=1, fd_flush=1.
- In RUN, e_mc_start & mc_done in the same cycle is treated as a single-cycle op: no stall.
- MC_WAIT, mc_done=1: all outputs 0; next state RUN. The op advances into E/M.
- MC_WAIT, mc_done=0 and cnt<MC_TIMEOUT-1: pc_stall=fd_stall=de_stall=1, em_flush=1; cnt increments.
- MC_WAIT, mc_done=0 and cnt==MC_TIMEOUT-1: mc_abort=1 and em_flush=1; stalls are released; next state RUN.
- In MC_WAIT, load-use, imem_ready and e_redirect are ignored.
- Outputs are combinational (Mealy) from state, cnt and inputs. Only state and cnt are registered.

## Timing
- Hazard response has zero latency: controls are valid in the same cycle as the causing inputs, before the next rising edge.
- A load-use hazard costs exactly 1 stall cycle, provided e_is_load drops once the bubble moves into E.
- A redirect costs 2 squashed instructions (F/D and D/E contents).
- A multi-cycle op taking N cycles (done on cycle N, N≥2) stalls for N-1 cycles.
- After reset deassertion, RUN is entered after exactly DRAIN_CYCLES rising edges.
- Asserting reset mid-MC_WAIT returns immediately to DRAIN. mc_abort is not asserted.

## Configuration
- PIPELINE_CONTROL_PERF_EN defined: adds three outputs.
  - stall_cycles[31:0]: counts RUN/MC_WAIT cycles with pc_stall=1.
  - flush_events[31:0]: counts RUN cycles with e_redirect=1.
  - mc_aborts[31:0]: counts mc_abort pulses.
  - All three reset to 0, wrap modulo 2^32, and do not count while in DRAIN.
- Macro undefined: these ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared definitions file pipe_ctrl_defs holds:
  - state encodings ST_DRAIN=2'd0, ST_RUN=2'd1, ST_MC_WAIT=2'd2;
  - the NOP constant 32'h00000013, shared with the pipeline registers;
  - register index width 5.
- One sub-module: load_use_detect, purely combinational, implementing the condition in RUN rule 3.

## Test plan
- Reset for 3 cycles, then release with DRAIN_CYCLES=2 → all flushes and pc_stall=1 for 2 cycles; RUN on the 3rd cycle with all outputs 0.
- e_is_load=1, e_rd=5, d_rs2=5, d_uses_rs2=1 → pc_stall=fd_stall=de_flush=1 for one cycle. Repeat with e_rd=0 → no stall.
- e_redirect=1 together with a load-use match → only fd_flush=de_flush=1; pc_stall=0.
- e_mc_start held with mc_done on the 4th cycle → stalls plus em_flush in cycles 1–3; all outputs 0 in cycle 4; state RUN afterwards.
- MC_TIMEOUT=8, mc_done never asserted → stalls for 7 cycles, then mc_abort=1 for exactly 1 cycle; with PIPELINE_CONTROL_PERF_EN, mc_aborts=1 and stall_cycles=7.
- imem_ready=0 for 3 cycles in RUN → pc_stall=fd_flush=1 for 3 cycles. Assert reset mid-MC_WAIT → state DRAIN immediately, no mc_abort.
